// File: rtl/vid_line_fetch.sv
// Video line fetcher: walks a frame line by line, issuing 8-word read bursts
// on the bus whenever the pixel FIFO has room, and flags late line starts.
module vid_line_fetch #(
   parameter int unsigned BURST_WORDS = 8,
   parameter logic [3:0]  TARGET      = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic [31:0] base_address,
   input  logic [31:0] lineinc,
   input  logic [12:0] vsize,
   input  logic [5:0]  bursts_per_line,
   input  logic [7:0]  fifo_space,
   input  logic        ackin,
   input  logic        rd_valid,
   output logic [1:0]  reqout,
   output logic [2:0]  cmdout,
   output logic [1:0]  lenout,
   output logic [31:0] addrdataout,
   output logic [3:0]  reqtar,
   output logic        busy,
   output logic        line_done,
   output logic        frame_done,
   output logic        underrun
);

   typedef enum logic [2:0] {IDLE, WAIT_LINE, CHECK, REQ, DATA} state_t;

   localparam logic [7:0] BURST_SPACE = 8'(BURST_WORDS);
   localparam logic [2:0] BEAT_LAST   = 3'(BURST_WORDS - 1);

   state_t      state, state_nx;
   logic [31:0] line_addr, line_addr_nx, cur_addr, cur_addr_nx;
   logic [12:0] line_cnt, line_cnt_nx, line_cnt_inc;
   logic [5:0]  burst_cnt, burst_cnt_nx, burst_cnt_inc;
   logic [2:0]  beat_cnt, beat_cnt_nx;
   logic        restart_pend, restart_pend_nx;
   logic        underrun_nx, line_done_nx, frame_done_nx;

   assign line_cnt_inc  = line_cnt + 13'd1;
   assign burst_cnt_inc = burst_cnt + 6'd1;

   always_comb begin
      state_nx        = state;
      line_addr_nx    = line_addr;
      cur_addr_nx     = cur_addr;
      line_cnt_nx     = line_cnt;
      burst_cnt_nx    = burst_cnt;
      beat_cnt_nx     = beat_cnt;
      restart_pend_nx = restart_pend;
      underrun_nx     = underrun;
      line_done_nx    = 1'b0;
      frame_done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (enable && frame_start) begin
               state_nx     = WAIT_LINE;
               line_addr_nx = base_address;
               line_cnt_nx  = 13'd0;
               underrun_nx  = 1'b0;
            end
         end
         WAIT_LINE, CHECK: begin
            if (!enable) begin
               state_nx = IDLE;
            end else if (frame_start) begin
               state_nx     = WAIT_LINE;
               line_addr_nx = base_address;
               line_cnt_nx  = 13'd0;
               underrun_nx  = 1'b0;
            end else if (state == WAIT_LINE) begin
               if (line_start && (line_cnt < vsize)) begin
                  if (bursts_per_line == 6'd0) begin
                     // Empty line: complete it on the spot without touching the bus
                     line_done_nx  = 1'b1;
                     frame_done_nx = (line_cnt_inc == vsize);
                     line_cnt_nx   = line_cnt_inc;
                     line_addr_nx  = line_addr + lineinc;
                  end else begin
                     state_nx     = CHECK;
                     cur_addr_nx  = line_addr;
                     burst_cnt_nx = 6'd0;
                  end
               end
            end else begin
               if (line_start) underrun_nx = 1'b1;
               if (fifo_space >= BURST_SPACE) state_nx = REQ;
            end
         end
         REQ: begin
            if (frame_start)     restart_pend_nx = 1'b1;
            else if (line_start) underrun_nx     = 1'b1;
            if (ackin) begin
               state_nx    = DATA;
               beat_cnt_nx = 3'd0;
            end
         end
         DATA: begin
            if (frame_start)     restart_pend_nx = 1'b1;
            else if (line_start) underrun_nx     = 1'b1;
            if (rd_valid) begin
               beat_cnt_nx = beat_cnt + 3'd1;
               if (beat_cnt == BEAT_LAST) begin
                  cur_addr_nx  = cur_addr + 32'd32;
                  burst_cnt_nx = burst_cnt_inc;
                  if (!enable) begin
                     state_nx        = IDLE;
                     restart_pend_nx = 1'b0;
                  end else if (restart_pend || frame_start) begin
                     // A frame restart arrived mid-burst; drop the line silently
                     state_nx        = WAIT_LINE;
                     restart_pend_nx = 1'b0;
                     line_addr_nx    = base_address;
                     line_cnt_nx     = 13'd0;
                     underrun_nx     = 1'b0;
                  end else if (burst_cnt_inc == bursts_per_line) begin
                     state_nx      = WAIT_LINE;
                     line_done_nx  = 1'b1;
                     frame_done_nx = (line_cnt_inc == vsize);
                     line_cnt_nx   = line_cnt_inc;
                     line_addr_nx  = line_addr + lineinc;
                  end else begin
                     state_nx = CHECK;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         line_cnt     <= 13'd0;
         burst_cnt    <= 6'd0;
         beat_cnt     <= 3'd0;
         restart_pend <= 1'b0;
         underrun     <= 1'b0;
         line_done    <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_nx;
         line_cnt     <= line_cnt_nx;
         burst_cnt    <= burst_cnt_nx;
         beat_cnt     <= beat_cnt_nx;
         restart_pend <= restart_pend_nx;
         underrun     <= underrun_nx;
         line_done    <= line_done_nx;
         frame_done   <= frame_done_nx;
      end
   end

   always_ff @(posedge clk) begin
      line_addr <= line_addr_nx;
      cur_addr  <= cur_addr_nx;
   end

   always_comb begin
      reqout      = 2'b00;
      cmdout      = 3'b000;
      lenout      = 2'b00;
      addrdataout = 32'h0;
      reqtar      = TARGET;
      busy        = (state != IDLE);
      if (state == REQ) begin
         reqout      = 2'b01;
         cmdout      = 3'b001;
         lenout      = 2'b11;
         addrdataout = cur_addr;
      end
   end

endmodule

// File: doc/vid_line_fetch.md
VID_LINE_FETCH -- requirements
Module: vid_line_fetch

Interface
REQ-001 Parameter BURST_WORDS, default 8, SHALL set the number of 32-bit words per read burst; the only legal value is 8, which matches lenout=2'b11.
REQ-002 Parameter TARGET, default 4'h0, SHALL set the bus target ID driven on reqtar.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: synchronous active-high reset.
- enable, in, 1: controller enable (cr.en).
- frame_start, in, 1: one-cycle pulse at the end of vertical blank.
- line_start, in, 1: one-cycle pulse marking the line-fetch window.
- base_address, in, 32: frame base byte address.
- lineinc, in, 32: byte stride between lines.
- vsize, in, 13: displayed lines per frame.
- bursts_per_line, in, 6: read bursts per line.
- fifo_space, in, 8: free words in the pixel FIFO.
- ackin, in, 1: bus accepts the current request.
- rd_valid, in, 1: one returned read data beat.
- reqout, out, 2: bus request code.
- cmdout, out, 3: bus command.
- lenout, out, 2: burst length code.
- addrdataout, out, 32: request address.
- reqtar, out, 4: request target ID.
- busy, out, 1: high in any state other than IDLE.
- line_done, out, 1: one-cycle pulse when a line fetch completes.
- frame_done, out, 1: one-cycle pulse when the last line of a frame completes.
- underrun, out, 1: sticky late-fetch flag.

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT_LINE, CHECK, REQ and DATA, each held in a register.
REQ-006 IDLE -> WAIT_LINE SHALL occur on enable=1 and frame_start=1, loading line_addr=base_address, line_cnt=0 and clearing underrun.
REQ-007 WAIT_LINE -> CHECK SHALL occur on line_start=1 while line_cnt<vsize, loading cur_addr=line_addr and burst_cnt=0.
REQ-008 A line_start arriving in WAIT_LINE while line_cnt>=vsize SHALL be ignored.
REQ-009 When bursts_per_line=0, line_start in WAIT_LINE SHALL produce line_done the next cycle, issue no request, and increment line_cnt.
REQ-010 CHECK -> REQ SHALL occur when fifo_space>=BURST_WORDS; otherwise the FSM SHALL stay in CHECK.
REQ-011 In REQ, the outputs SHALL be reqout=2'b01, cmdout=3'b001 (read), lenout=2'b11, addrdataout=cur_addr and reqtar=TARGET, all held stable until the cycle in which ackin=1.
REQ-012 In REQ, ackin=1 SHALL move the FSM to DATA on the next edge, with a beat counter cleared to 0.
REQ-013 Outside REQ, reqout SHALL be 2'b00, cmdout 3'b000, lenout 2'b00 and addrdataout 32'h0.
REQ-014 In DATA, each rd_valid=1 SHALL increment the beat counter, and rd_valid outside DATA SHALL be ignored.
REQ-015 On the 8th beat, cur_addr SHALL advance by 32 and burst_cnt by 1; if the new burst_cnt equals bursts_per_line, the line completes, otherwise the FSM SHALL return to CHECK.
REQ-016 Line completion SHALL pulse line_done for one cycle, increment line_cnt, add lineinc to line_addr, and return the FSM to WAIT_LINE.
REQ-017 When the completed line makes line_cnt equal vsize, frame_done SHALL pulse in the same cycle as line_done.
REQ-018 All address arithmetic SHALL be unsigned 32-bit, wrapping modulo 2^32 without any error indication.
REQ-019 A line_start received while the FSM is in CHECK, REQ or DATA SHALL set underrun=1 and SHALL NOT queue a fetch.
REQ-020 A frame_start received while the FSM is in WAIT_LINE or CHECK SHALL immediately reload the frame state (line_addr, line_cnt, underrun) and go to WAIT_LINE.
REQ-021 A frame_start received while the FSM is in REQ or DATA SHALL set restart_pend; the current burst SHALL complete, and the block SHALL then reload the frame state and go to WAIT_LINE without pulsing line_done.
REQ-022 Deasserting enable in WAIT_LINE or CHECK SHALL move the FSM to IDLE on the next edge.
REQ-023 Deasserting enable in REQ or DATA SHALL let the accepted or pending burst finish, after which the FSM SHALL go to IDLE.
REQ-024 An issued request SHALL never be withdrawn before ackin.
REQ-025 If frame_start and line_start are asserted in the same cycle, frame_start SHALL take priority and line_start SHALL be ignored.

Reset
REQ-026 While reset=1 at a clk edge, the FSM SHALL enter IDLE and every counter, restart_pend and underrun SHALL clear to 0.
REQ-027 While reset=1, outputs SHALL be reqout=0, cmdout=0, lenout=0, addrdataout=0, reqtar=TARGET, busy=0, line_done=0 and frame_done=0.
REQ-028 Reset SHALL override every other input, including a reset asserted in the middle of a burst.

Verification
REQ-029 Basic line fetch: base=0x1000_0000, lineinc=0x800, vsize=2, bursts_per_line=2, fifo_space=64, ackin 1 cycle after request, frame_start then line_start -> requests at 0x1000_0000 and 0x1000_0020, then line_done.
REQ-030 Second line: continuing REQ-029, the second line_start -> requests at 0x1000_0800 and 0x1000_0820, and line_done and frame_done pulse together.
REQ-031 FIFO stall: fifo_space=7 -> FSM holds in CHECK with reqout=0; fifo_space=8 -> request issued in REQ the next cycle.
REQ-032 ackin held low for 10 cycles -> reqout, cmdout, lenout and addrdataout unchanged throughout; DATA entered the cycle after ackin=1.
REQ-033 line_start during DATA -> underrun=1 and burst count unchanged; frame_start during DATA -> burst finishes with 8 beats, FSM enters WAIT_LINE, line_cnt=0 and underrun=0.
REQ-034 Address wrap: base=0xFFFF_FFE0, bursts_per_line=2 -> second request at 0x0000_0000; reset asserted in REQ -> reqout=0 and busy=0 the next cycle.
